// File: rtl/lsu_bus.sv
// Multi-cycle load/store unit: aligns lanes, builds strobes, extends loads, flags misaligned/illegal accesses.
// Latency: legal access responds 3 cycles after acceptance (more with bus stalls); errors respond next cycle.
// Backpressure: one access outstanding; req_ready low until the response is taken, mem_* held until mem_ready.
//
// Ports: req_* (execute-side request handshake), resp_* (result handshake),
//        mem_* (data-memory bus port: request handshake plus mem_rvalid completion).
module lsu_bus #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rerr
);
    localparam int         STRB_W = DATA_W / 8;
    localparam int         OFF_W  = $clog2(STRB_W);
    localparam logic [3:0] STRB_N = 4'(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    // Request decode, only consumed when a request is accepted in IDLE.
    logic [OFF_W-1:0]    req_off;
    logic [3:0]          req_n;
    logic [3:0]          align_mask;
    logic                req_bad;
    logic [STRB_W-1:0]   strb_base;

    assign req_off    = req_addr[OFF_W-1:0];
    assign req_n      = 4'd1 << req_size;
    assign align_mask = req_n - 4'd1;
    // Misaligned, or wider than the bus (size 3 on a 32-bit bus).
    assign req_bad    = (|(req_addr[2:0] & align_mask[2:0])) || (req_n > STRB_N);
    assign strb_base  = STRB_W'((9'd1 << req_n) - 9'd1);

    // Load path: shift the addressed lane down, then sign/zero fill above the access width.
    logic [DATA_W-1:0]   ld_raw;
    logic [DATA_W-1:0]   ld_ext;
    logic                ld_sbit;

    always_comb begin
        ld_raw = mem_rdata >> {off_q, 3'b000};
        ld_ext = '0;
        case (size_q)
            2'd0:    ld_sbit = ld_raw[7];
            2'd1:    ld_sbit = ld_raw[15];
            2'd2:    ld_sbit = ld_raw[31];
            default: ld_sbit = ld_raw[DATA_W-1];
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            ld_ext[i] = ((i >> 3) < (1 << size_q)) ? ld_raw[i] : (signed_q & ld_sbit);
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = mem_wen_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mem_addr_d  = req_addr & ~ADDR_W'(STRB_W - 1);
                    mem_wen_d   = req_wen;
                    mem_wdata_d = req_wdata << {req_off, 3'b000};
                    mem_wstrb_d = req_wen ? (strb_base << req_off) : '0;
                    off_d       = req_off;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    if (req_bad) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A completion seen in the same cycle as mem_ready is not ours to count.
                if (mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    resp_err_d   = mem_rerr;
                    resp_rdata_d = (mem_rerr || mem_wen_q) ? '0 : ld_ext;
                    state_d      = S_RESP;
                end
            end
            default: begin
                if (resp_ready) state_d = S_IDLE;
            end
        endcase
    end

    // Registered so req_ready has no path from req_valid/resp_ready.
    assign req_ready_d = (state_d == S_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_valid  = (state_q == S_REQ);
    assign resp_valid = (state_q == S_RESP);
    assign mem_addr   = mem_addr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_lsu_bus.sv
module tb_lsu_bus;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic        req_valid, req_ready, req_wen, req_signed;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid, mem_rerr;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;

    logic        c_req_valid, c_req_ready, c_req_wen, c_req_signed;
    logic [31:0] c_req_addr;
    logic [1:0]  c_req_size;
    logic [31:0] c_req_wdata;
    logic        c_resp_valid, c_resp_ready, c_resp_err;
    logic [31:0] c_resp_rdata;
    logic        c_mem_valid, c_mem_ready, c_mem_wen, c_mem_rvalid, c_mem_rerr;
    logic [31:0] c_mem_addr;
    logic [31:0] c_mem_wdata, c_mem_rdata;
    logic [3:0]  c_mem_wstrb;

    lsu_bus #(.DATA_W(64), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
        .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
    );

    lsu_bus #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clock(clock), .reset(reset),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_addr(c_req_addr), .req_wen(c_req_wen),
        .req_size(c_req_size), .req_signed(c_req_signed), .req_wdata(c_req_wdata),
        .resp_valid(c_resp_valid), .resp_ready(c_resp_ready), .resp_rdata(c_resp_rdata), .resp_err(c_resp_err),
        .mem_valid(c_mem_valid), .mem_ready(c_mem_ready), .mem_addr(c_mem_addr), .mem_wen(c_mem_wen),
        .mem_wdata(c_mem_wdata), .mem_wstrb(c_mem_wstrb), .mem_rvalid(c_mem_rvalid),
        .mem_rdata(c_mem_rdata), .mem_rerr(c_mem_rerr)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Independent reference for load extension.
    function automatic logic [63:0] model_load(input logic [63:0] bus, input logic [2:0] off,
                                               input logic [1:0] size, input bit sg);
        logic [63:0] raw;
        raw = bus >> {off, 3'b000};
        case (size)
            2'd0: model_load = sg ? {{56{raw[7]}}, raw[7:0]} : {56'd0, raw[7:0]};
            2'd1: model_load = sg ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            2'd2: model_load = sg ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            default: model_load = raw;
        endcase
    endfunction

    // Drivers only; call at a negedge, return at the negedge after the accept edge.
    task automatic send_req(input logic [31:0] a, input bit w, input logic [1:0] s, input bit sg,
                            input logic [63:0] wd);
        req_addr = a; req_wen = w; req_size = s; req_signed = sg; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic mem_complete(input logic [63:0] d, input bit r);
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = d; mem_rerr = r;
        @(negedge clock);
        mem_rvalid = 1'b0; mem_rerr = 1'b0;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b want 0", req_ready); end
        checks++; if ({mem_valid, mem_wen, resp_valid, resp_err} !== 4'b0) begin errors++;
            $display("FAIL rst_ctrl got %b want 0000", {mem_valid, mem_wen, resp_valid, resp_err}); end
        checks++; if ({mem_addr, mem_wdata, mem_wstrb, resp_rdata} !== '0) begin errors++;
            $display("FAIL rst_data addr=%h wdata=%h strb=%h rdata=%h want 0", mem_addr, mem_wdata, mem_wstrb, resp_rdata); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_load_signed();
        exp_t e;
        exp_q.push_back('{64'hFFFF_FFFF_FFFF_8001, 1'b0});
        send_req(32'h8000_0006, 1'b0, 2'd1, 1'b1, 64'd0);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL lds_mem_valid got %0b want 1", mem_valid); end
        checks++; if (mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL lds_mem_addr got %h want 80000000", mem_addr); end
        checks++; if (mem_wstrb !== 8'h00 || mem_wen !== 1'b0) begin errors++;
            $display("FAIL lds_strb_wen got %h/%0b want 00/0", mem_wstrb, mem_wen); end
        mem_complete(64'h8001_2233_4455_6677, 1'b0);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lds_latency resp_valid got %0b want 1 at T+3", resp_valid); end
        e = exp_q.pop_front();
        checks++; if (resp_rdata !== e.rdata || resp_err !== e.err) begin errors++;
            $display("FAIL lds_result got %h/%0b want %h/%0b", resp_rdata, resp_err, e.rdata, e.err); end
        take_resp();
    endtask

    task automatic test_load_unsigned();
        exp_t e;
        exp_q.push_back('{64'h0000_0000_0000_0080, 1'b0});
        send_req(32'h8000_0007, 1'b0, 2'd0, 1'b0, 64'd0);
        mem_complete(64'h8001_2233_4455_6677, 1'b0);
        e = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err) begin errors++;
            $display("FAIL ldu_result got v=%0b %h/%0b want %h/%0b", resp_valid, resp_rdata, resp_err, e.rdata, e.err); end
        take_resp();
    endtask

    task automatic test_misaligned();
        exp_t e;
        exp_q.push_back('{64'd0, 1'b1});
        send_req(32'h8000_0003, 1'b0, 2'd2, 1'b1, 64'd0);
        checks++; if (resp_valid !== 1'b1 || mem_valid !== 1'b0) begin errors++;
            $display("FAIL mis_timing resp_valid=%0b mem_valid=%0b want 1/0", resp_valid, mem_valid); end
        e = exp_q.pop_front();
        checks++; if (resp_rdata !== e.rdata || resp_err !== e.err) begin errors++;
            $display("FAIL mis_result got %h/%0b want %h/%0b", resp_rdata, resp_err, e.rdata, e.err); end
        take_resp();
        checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL mis_after mem_valid=%0b req_ready=%0b want 0/1", mem_valid, req_ready); end
        exp_q.push_back('{64'd0, 1'b1});
        send_req(32'h8000_0004, 1'b0, 2'd3, 1'b0, 64'd0);
        e = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || mem_valid !== 1'b0 || resp_err !== e.err) begin errors++;
            $display("FAIL mis_dw got v=%0b mv=%0b err=%0b want 1/0/%0b", resp_valid, mem_valid, resp_err, e.err); end
        take_resp();
    endtask

    task automatic test_store();
        exp_t e;
        exp_q.push_back('{64'd0, 1'b0});
        send_req(32'h8000_0004, 1'b1, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF);
        checks++; if (mem_wstrb !== 8'hF0) begin errors++; $display("FAIL st_strb got %h want f0", mem_wstrb); end
        checks++; if (mem_wdata[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_wdata got %h want deadbeef", mem_wdata[63:32]); end
        checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h8000_0000) begin errors++;
            $display("FAIL st_wen_addr got %0b/%h want 1/80000000", mem_wen, mem_addr); end
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL st_wait_rvalid resp_valid got %0b want 0", resp_valid); end
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        mem_rvalid = 1'b0;
        e = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err) begin errors++;
            $display("FAIL st_result got v=%0b %h/%0b want %h/%0b", resp_valid, resp_rdata, resp_err, e.rdata, e.err); end
        take_resp();
    endtask

    task automatic test_dw32();
        c_req_addr = 32'd0; c_req_size = 2'd3; c_req_wen = 1'b0; c_req_signed = 1'b0;
        c_req_valid = 1'b1;
        @(negedge clock);
        c_req_valid = 1'b0;
        checks++; if (c_resp_valid !== 1'b1 || c_resp_err !== 1'b1 || c_mem_valid !== 1'b0 || c_resp_rdata !== 32'd0) begin
            errors++; $display("FAIL w32_size3 v=%0b err=%0b mv=%0b rdata=%h want 1/1/0/0", c_resp_valid, c_resp_err, c_mem_valid, c_resp_rdata); end
        c_resp_ready = 1'b1;
        @(negedge clock);
        c_resp_ready = 1'b0;
        c_req_addr = 32'h0000_0006; c_req_size = 2'd1; c_req_signed = 1'b1;
        c_req_valid = 1'b1;
        @(negedge clock);
        c_req_valid = 1'b0;
        checks++; if (c_mem_valid !== 1'b1 || c_mem_addr !== 32'h0000_0004) begin errors++;
            $display("FAIL w32_addr mv=%0b addr=%h want 1/00000004", c_mem_valid, c_mem_addr); end
        c_mem_ready = 1'b1;
        @(negedge clock);
        c_mem_ready = 1'b0; c_mem_rvalid = 1'b1; c_mem_rdata = 32'h8001_2233;
        @(negedge clock);
        c_mem_rvalid = 1'b0;
        checks++; if (c_resp_valid !== 1'b1 || c_resp_rdata !== 32'hFFFF_8001 || c_resp_err !== 1'b0) begin errors++;
            $display("FAIL w32_load v=%0b %h/%0b want 1 ffff8001/0", c_resp_valid, c_resp_rdata, c_resp_err); end
        c_resp_ready = 1'b1;
        @(negedge clock);
        c_resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_q.push_back('{64'd0, 1'b1});
        send_req(32'h8000_0008, 1'b0, 2'd3, 1'b0, 64'd0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0008 || mem_wstrb !== 8'h00 ||
                          req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++;
                $display("FAIL bp_req_hold cyc%0d mv=%0b addr=%h strb=%h rr=%0b rv=%0b want 1/80000008/00/0/0",
                         i, mem_valid, mem_addr, mem_wstrb, req_ready, resp_valid); end
            mem_rvalid = (i == 2);
            mem_rdata = 64'h1234_5678_9ABC_DEF0;
            @(negedge clock);
        end
        mem_ready = 1'b1; mem_rvalid = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        checks++; if (resp_valid !== 1'b0 || mem_valid !== 1'b0) begin errors++;
            $display("FAIL bp_same_cycle_rvalid rv=%0b mv=%0b want 0/0", resp_valid, mem_valid); end
        @(negedge clock);
        mem_rvalid = 1'b1; mem_rerr = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        mem_rvalid = 1'b0; mem_rerr = 1'b0;
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_resp_hold cyc%0d v=%0b %h/%0b rr=%0b want 1 %h/%0b 0",
                                   i, resp_valid, resp_rdata, resp_err, req_ready, e.rdata, e.err); end
            @(negedge clock);
        end
        take_resp();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release v=%0b rr=%0b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        send_req(32'h8000_0010, 1'b0, 2'd2, 1'b0, 64'd0);
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        checks++; if ({req_ready, mem_valid, mem_wen, resp_valid, resp_err} !== 5'b0 ||
                      {mem_addr, mem_wdata, mem_wstrb, resp_rdata} !== '0) begin errors++;
            $display("FAIL mid_rst_outputs ctl=%b addr=%h rdata=%h want 0", {req_ready, mem_valid, mem_wen, resp_valid, resp_err},
                     mem_addr, resp_rdata); end
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (resp_valid !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
                $display("FAIL mid_rst_late_rvalid cyc%0d rv=%0b mv=%0b rr=%0b want 0/0/1", i, resp_valid, mem_valid, req_ready); end
            @(negedge clock);
        end
        exp_q.push_back('{64'hFFFF_FFFF_8765_4321, 1'b0});
        send_req(32'h8000_0010, 1'b0, 2'd2, 1'b1, 64'd0);
        mem_complete(64'h0000_0000_8765_4321, 1'b0);
        e = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err) begin errors++;
            $display("FAIL mid_rst_next got v=%0b %h/%0b want %h/%0b", resp_valid, resp_rdata, resp_err, e.rdata, e.err); end
        take_resp();
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] a;
        logic [1:0]  s;
        bit          w, sg, bad;
        logic [63:0] wd, bus, mask, exp_wd;
        logic [2:0]  m;
        logic [3:0]  nb;
        logic [7:0]  strb;
        for (int k = 0; k < 16; k++) begin
            a   = 32'h8000_0000 | 32'($urandom_range(0, 63));
            s   = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            wd  = {$urandom, $urandom};
            bus = {$urandom, $urandom};
            m   = 3'((1 << s) - 1);
            bad = (a[2:0] & m) != 3'd0;
            nb  = 4'd1 << s;
            strb = (w && !bad) ? (8'((16'd1 << nb) - 16'd1) << a[2:0]) : 8'h00;
            for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{strb[b]}};
            exp_wd = wd << {a[2:0], 3'b000};
            exp_q.push_back('{(bad || w) ? 64'd0 : model_load(bus, a[2:0], s, sg), bad});
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k%0d got %0b want 1", k, req_ready); end
            send_req(a, w, s, sg, wd);
            if (!bad) begin
                checks++; if (mem_valid !== 1'b1 || mem_addr !== (a & ~32'd7) || mem_wstrb !== strb || mem_wen !== w ||
                              (mem_wdata & mask) !== (exp_wd & mask)) begin errors++;
                    $display("FAIL b2b_bus k%0d mv=%0b addr=%h strb=%h wen=%0b wdata=%h want addr=%h strb=%h wdata=%h",
                             k, mem_valid, mem_addr, mem_wstrb, mem_wen, mem_wdata & mask, a & ~32'd7, strb, exp_wd & mask); end
                mem_complete(bus, 1'b0);
            end
            e = exp_q.pop_front();
            checks++; if (resp_valid !== 1'b1 || mem_valid !== 1'b0 || resp_rdata !== e.rdata || resp_err !== e.err) begin
                errors++; $display("FAIL b2b_resp k%0d a=%h s=%0d w=%0b got v=%0b %h/%0b want %h/%0b",
                                   k, a, s, w, resp_valid, resp_rdata, resp_err, e.rdata, e.err); end
            take_resp();
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = '0; req_signed = 1'b0; req_wdata = '0;
        resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
        c_req_valid = 1'b0; c_req_addr = '0; c_req_wen = 1'b0; c_req_size = '0; c_req_signed = 1'b0; c_req_wdata = '0;
        c_resp_ready = 1'b0; c_mem_ready = 1'b0; c_mem_rvalid = 1'b0; c_mem_rdata = '0; c_mem_rerr = 1'b0;
        test_reset();
        test_load_signed();
        test_load_unsigned();
        test_misaligned();
        test_store();
        test_dw32();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_bus.md
# lsu_bus

Parametrised, multi-cycle load/store unit that replaces the single-cycle combinational LSU path. It sits between the execute stage and the data-memory bus port, and accepts one load or store per request handshake. It performs lane alignment, byte-strobe generation and sign/zero extension, and detects misalignment. It issues one bus transaction and returns a result or an error through a response handshake. Only one access is outstanding at a time.

## Interface
Parameters:
- DATA_W, 64, bus and register data width in bits; legal values are 32 and 64.
- ADDR_W, 32, address width in bits.

Ports:
- clock  in  1  the only clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  log2 of the access size in bytes (0 = byte, 1 = half, 2 = word, 3 = double).
- req_signed  in  1  sign-extend load result; ignored for stores.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access, illegal size, or bus error.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accepts the request.
- mem_addr  out  ADDR_W  req_addr with the low log2(DATA_W/8) bits cleared.
- mem_wen  out  1  bus write.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_wstrb  out  DATA_W/8  byte strobes; all zero for loads.
- mem_rvalid  in  1  bus completion; used for both reads and writes.
- mem_rdata  in  DATA_W  full-word read data.
- mem_rerr  in  1  bus error, qualified by mem_rvalid.

## Operation
- The FSM has four states: IDLE, REQ, WAIT and RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, the unit latches addr, wen, size, signed and wdata.
  - Error check: the access is an error if addr mod 2^size ≠ 0, or if 2^size > DATA_W/8.
  - On error, the next state is RESP with err = 1, and no bus access is made.
  - Otherwise, the next state is REQ.
- REQ:
  - mem_valid = 1. The mem_* outputs stay stable until mem_ready.
  - On mem_ready, the next state is WAIT.
  - If mem_ready and mem_rvalid arrive in the same cycle, the rvalid is ignored; only the WAIT-state rvalid counts.
- WAIT: on mem_rvalid, the unit latches mem_rdata and mem_rerr, then moves to RESP.
- RESP:
  - resp_valid = 1, and resp_rdata and resp_err are held stable.
  - On resp_ready, the next state is IDLE.
  - req_ready is 0, so there is no back-to-back bypass.
- mem_rvalid is ignored in every state except WAIT.
- Lane rules, with off = addr[log2(DATA_W/8)-1:0] and n = 2^size:
  - mem_wstrb = ((1<<n)-1) << off.
  - mem_wdata = req_wdata << (8*off); bytes outside the strobe are don't-care.
  - Load: raw = mem_rdata >> (8*off), truncated to 8n bits. The top bit of the truncated value is replicated when req_signed = 1; otherwise the upper bits are zero-filled.
- Size 3 with DATA_W = 32 is always an error.
- Bus error: resp_err = 1 and resp_rdata = 0.
- Store: resp_rdata = 0. A store still waits for mem_rvalid before responding.

## Timing
- Reset (reset = 0 at a clock edge):
  - The state goes to IDLE.
  - req_ready = 1 once reset deasserts; it is 0 while reset is held.
  - mem_valid, mem_wen, resp_valid and resp_err = 0.
  - mem_addr, mem_wdata, mem_wstrb and resp_rdata = 0.
- Reset mid-operation aborts the access. No response is produced, and a late mem_rvalid after reset is ignored.
- Minimum latency for a legal access, with the request accepted at edge T:
  - mem_valid is high in cycle T+1.
  - With mem_ready in T+1 and mem_rvalid in T+2, resp_valid is high in T+3.
- Misaligned or illegal access accepted at T: resp_valid is high in T+1.
- All outputs are registered or decoded from the state only. There is no combinational path from the inputs to req_ready, mem_valid or resp_valid.
- Throughput is at most one access per 4 cycles, or per 2 cycles for errors.

## Test plan
- DATA_W = 64, load addr 0x8000_0006, size 1, signed; mem_rdata 0x8001_2233_4455_6677 -> mem_addr 0x8000_0000, mem_wstrb 0x00, resp_rdata 0xFFFF_FFFF_FFFF_8001, err 0, resp at T+3.
- Same access unsigned, size 0, addr 0x8000_0007 -> resp_rdata 0x0000_0000_0000_0080.
- Store addr 0x8000_0004, size 2, wdata 0xDEAD_BEEF -> mem_wstrb 0xF0, mem_wdata[63:32] 0xDEAD_BEEF, mem_wen 1; after mem_rvalid, resp_rdata 0, err 0.
- Load addr 0x8000_0003, size 2 -> no mem_valid ever, resp_valid at T+1, err 1, rdata 0. DATA_W = 32 with size 3 -> err 1.
- Back-pressure: mem_ready low for 5 cycles and resp_ready low for 3 cycles -> mem_* and resp_* stable throughout, req_ready 0; a spurious mem_rvalid during REQ is ignored; mem_rerr = 1 -> err 1, rdata 0.
- Reset asserted while in WAIT, then mem_rvalid pulses -> IDLE, no resp_valid, all outputs at reset values, next request handled normally.
